// File: rtl/multi_rule_sniffer_pkg.sv
// multi_rule_sniffer_pkg: shared types and protocol constants for the multi-rule sniffer
package sniffer_pkg;
  typedef enum logic [1:0] {RULE_OFF, RULE_MAC, RULE_IP, RULE_PORT} rule_type_t;
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_REPORT} state_t;
  typedef struct packed {
    rule_type_t  kind;
    logic [47:0] value;
  } rule_t;
  localparam logic [15:0] ETH_IPV4  = 16'h0800;
  localparam logic [15:0] ETH_VLAN  = 16'h8100;
  localparam logic [7:0]  PROTO_TCP = 8'd6;
  localparam logic [7:0]  PROTO_UDP = 8'd17;
endpackage

// File: rtl/multi_rule_sniffer_rule_matcher.sv
// rule_matcher: one programmable rule, sticky per-packet match bit cleared on sop
module rule_matcher
  import sniffer_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  rule_t       rule,
  input  logic        clr,
  input  logic        mac_v,
  input  logic [47:0] mac,
  input  logic        ip_v,
  input  logic [31:0] ip,
  input  logic        port_v,
  input  logic [15:0] port,
  output logic        match
);
  logic hit, match_q, match_d;
  // a field completing this beat either sets the sticky bit or a new sop clears it
  always_comb begin
    hit = (rule.kind == RULE_MAC && mac_v && mac == rule.value) ||
          (rule.kind == RULE_IP && ip_v && ip == rule.value[31:0]) ||
          (rule.kind == RULE_PORT && port_v && port == rule.value[15:0]);
    match_d = clr ? 1'b0 : match_q | hit;
  end
  assign match = match_d;
  // sticky match register
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) match_q <= 1'b0;
    else match_q <= match_d;
endmodule

// File: rtl/multi_rule_sniffer.sv
// multi_rule_sniffer: header parser + NUM_RULES matchers, hit counters and result-ring writer
// Optional 802.1Q tag skipping is enabled by defining SNIFFER_VLAN_EN.
module multi_rule_sniffer
  import sniffer_pkg::*;
#(
  parameter int          NUM_RULES  = 8,
  parameter int          CNT_W      = 32,
  parameter int          RING_DEPTH = 256,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [31:0]                data_in,
  input  logic                       sop,
  input  logic                       eop,
  input  logic                       valid,
  input  logic [1:0]                 empty,
  input  logic [5:0]                 error,
  output logic                       in_ready,
  input  logic                       cfg_we,
  input  logic [3:0]                 cfg_idx,
  input  logic [1:0]                 cfg_type,
  input  logic [47:0]                cfg_value,
  input  logic                       clr_counts,
  output logic [31:0]                addr_out,
  output logic                       write_enable,
  input  logic                       wr_ready,
  output logic [31:0]                data_out,
  output logic [NUM_RULES*CNT_W-1:0] hit_counts
);
  localparam int PTR_W = $clog2(RING_DEPTH);
  state_t           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d, eff;
  logic [31:0]      prev_q, prev_d;
  logic             vlan_q, vlan_d, ip_ok_q, ip_ok_d;
  logic [7:0]       proto_q, proto_d;
  logic [15:0]      bitmap_q, bitmap_d, seq_q, seq_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  rule_t            cfg_q [NUM_RULES];
  rule_t            cfg_d [NUM_RULES];
  rule_t            act_q [NUM_RULES];
  rule_t            act_d [NUM_RULES];
  logic [CNT_W-1:0] cnt_q [NUM_RULES];
  logic [CNT_W-1:0] cnt_d [NUM_RULES];
  logic             acc, sop_acc, hdr, end_acc, good, vlan_det;
  logic             mac_v, ip_v, port_v;
  logic [47:0]      mac;
  logic [31:0]      ip;
  logic [15:0]      port;
  logic [NUM_RULES-1:0] hits;
  logic             unused_empty;
  assign unused_empty = ^empty;
  assign in_ready     = state_q != S_REPORT;
  assign write_enable = state_q == S_REPORT;
  assign addr_out     = ADDR_BASE + 32'({ptr_q, 2'b00});
  assign data_out     = write_enable ? {seq_q, bitmap_q} : 32'h0;
  // field extraction: each field is presented on the beat that completes it, joined with the previous word
  always_comb begin
    acc     = valid && in_ready;
    sop_acc = acc && sop;
    hdr     = acc && !sop && state_q == S_HDR;
    end_acc = acc && eop && (sop || state_q == S_HDR || state_q == S_BODY);
    eff     = wcnt_q - {3'b0, vlan_q};
    mac_v   = hdr && (eff == 4'd1 || eff == 4'd2);
    mac     = eff == 4'd1 ? {prev_q, data_in[31:16]} : {prev_q[15:0], data_in};
    ip_v    = hdr && ip_ok_q && (eff == 4'd7 || eff == 4'd8);
    ip      = {prev_q[15:0], data_in[31:16]};
    port_v  = hdr && ip_ok_q && (proto_q == PROTO_TCP || proto_q == PROTO_UDP) && (eff == 4'd8 || eff == 4'd9);
    port    = eff == 4'd8 ? data_in[15:0] : data_in[31:16];
`ifdef SNIFFER_VLAN_EN
    vlan_det = hdr && eff == 4'd3 && !vlan_q && data_in[31:16] == ETH_VLAN;
`else
    vlan_det = 1'b0;
`endif
  end
  // header qualifiers: previous word, VLAN skip, IPv4/IHL check and protocol, all reset on sop
  always_comb begin
    prev_d  = acc ? data_in : prev_q;
    vlan_d  = sop_acc ? 1'b0 : vlan_q | vlan_det;
    ip_ok_d = sop_acc ? 1'b0 : (hdr && eff == 4'd3 && !vlan_det) ?
              (data_in[31:16] == ETH_IPV4 && data_in[11:8] == 4'd5) : ip_ok_q;
    proto_d = sop_acc ? 8'd0 : (hdr && eff == 4'd5) ? data_in[7:0] : proto_q;
  end
  // packet FSM, ring pointer and sequence number
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    ptr_d    = ptr_q;
    seq_d    = seq_q;
    bitmap_d = bitmap_q;
    good     = end_acc && error == 6'd0 && |hits;
    if (state_q == S_REPORT) begin
      if (wr_ready) begin
        state_d = S_IDLE;
        ptr_d   = ptr_q + PTR_W'(1);
        seq_d   = seq_q + 16'd1;
      end
    end else if (end_acc) begin
      state_d  = good ? S_REPORT : S_IDLE;
      bitmap_d = 16'(hits);
    end else if (sop_acc) begin
      state_d = S_HDR;
      wcnt_d  = 4'd1;
    end else if (hdr) begin
      wcnt_d  = wcnt_q + 4'd1;
      state_d = eff == 4'd9 ? S_BODY : S_HDR;
    end
  end
  // config table writes, active-table snapshot on sop, saturating counters where clear wins
  always_comb begin
    for (int i = 0; i < NUM_RULES; i++) begin
      cfg_d[i] = (cfg_we && cfg_idx == 4'(i)) ? rule_t'{kind: rule_type_t'(cfg_type), value: cfg_value} : cfg_q[i];
      act_d[i] = sop_acc ? cfg_q[i] : act_q[i];
      cnt_d[i] = clr_counts ? '0 : (good && hits[i] && cnt_q[i] != '1) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end
  end
  // state registers
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      prev_q   <= '0;
      vlan_q   <= 1'b0;
      ip_ok_q  <= 1'b0;
      proto_q  <= '0;
      bitmap_q <= '0;
      seq_q    <= '0;
      ptr_q    <= '0;
      for (int i = 0; i < NUM_RULES; i++) begin
        cfg_q[i] <= '0;
        act_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      prev_q   <= prev_d;
      vlan_q   <= vlan_d;
      ip_ok_q  <= ip_ok_d;
      proto_q  <= proto_d;
      bitmap_q <= bitmap_d;
      seq_q    <= seq_d;
      ptr_q    <= ptr_d;
      cfg_q    <= cfg_d;
      act_q    <= act_d;
      cnt_q    <= cnt_d;
    end
  for (genvar r = 0; r < NUM_RULES; r++) begin : g_rule
    rule_matcher u_match (
      .clk    (clk),
      .n_rst  (n_rst),
      .rule   (act_q[r]),
      .clr    (sop_acc),
      .mac_v  (mac_v),
      .mac    (mac),
      .ip_v   (ip_v),
      .ip     (ip),
      .port_v (port_v),
      .port   (port),
      .match  (hits[r])
    );
    assign hit_counts[r*CNT_W +: CNT_W] = cnt_q[r];
  end
endmodule

// File: tb/tb_multi_rule_sniffer.sv
// tb_multi_rule_sniffer: directed self-checking bench for multi_rule_sniffer (SNIFFER_VLAN_EN aware)
module tb_multi_rule_sniffer;
  localparam logic [31:0] BASE = 32'h1000_0000;
  logic        clk = 1'b0, n_rst = 1'b0;
  logic [31:0] data_in = '0;
  logic        sop = 1'b0, eop = 1'b0, valid = 1'b0;
  logic [1:0]  empty = '0;
  logic [5:0]  error = '0;
  logic        in_ready;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [1:0]  cfg_type = '0;
  logic [47:0] cfg_value = '0;
  logic        clr_counts = 1'b0;
  logic [31:0] addr_out, data_out;
  logic        write_enable;
  logic        wr_ready = 1'b0;
  logic [15:0] hit_counts;
  int          n_chk = 0, n_pass = 0, nwr = 0;
  logic [31:0] fr [16];
  multi_rule_sniffer #(
    .NUM_RULES(4), .CNT_W(4), .RING_DEPTH(256), .ADDR_BASE(BASE)
  ) dut (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .sop(sop), .eop(eop), .valid(valid),
    .empty(empty), .error(error), .in_ready(in_ready), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_type(cfg_type), .cfg_value(cfg_value), .clr_counts(clr_counts), .addr_out(addr_out),
    .write_enable(write_enable), .wr_ready(wr_ready), .data_out(data_out), .hit_counts(hit_counts)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic mk(input logic [47:0] dst, input logic [47:0] src, input logic [7:0] proto,
                    input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp, input logic [15:0] dp);
    fr[0]  = dst[47:16];
    fr[1]  = {dst[15:0], src[47:32]};
    fr[2]  = src[31:0];
    fr[3]  = {16'h0800, 16'h4500};
    fr[4]  = 32'h0040_0000;
    fr[5]  = {16'h0000, 8'h40, proto};
    fr[6]  = {16'hBEEF, sip[31:16]};
    fr[7]  = {sip[15:0], dip[31:16]};
    fr[8]  = {dip[15:0], sp};
    fr[9]  = {dp, 16'h0000};
    fr[10] = 32'hDEAD_0001;
    fr[11] = 32'hDEAD_0002;
    fr[12] = 32'hDEAD_0003;
  endtask
  task automatic set_rule(input logic [3:0] idx, input logic [1:0] typ, input logic [47:0] val);
    cfg_idx = idx; cfg_type = typ; cfg_value = val; cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask
  task automatic send(input int n, input logic [5:0] err, input bit do_eop, input int cfg_beat, input bit clr_eop);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1; sop = i == 0; eop = do_eop && i == n - 1; data_in = fr[i];
      error = eop ? err : 6'd0; cfg_we = i == cfg_beat; clr_counts = clr_eop && eop;
      @(posedge clk); #1;
    end
    valid = 1'b0; sop = 1'b0; eop = 1'b0; error = '0; cfg_we = 1'b0; clr_counts = 1'b0;
  endtask
  task automatic take_write(input logic [15:0] bm, input int hold);
    logic [31:0] ea, ed;
    ea = BASE + 32'((nwr % 256) * 4);
    ed = {16'(nwr), bm};
    for (int h = 0; h <= hold; h++) begin
      chk("we", 64'(write_enable), 64'd1);
      chk("addr", 64'(addr_out), 64'(ea));
      chk("data", 64'(data_out), 64'(ed));
      chk("rdy_rep", 64'(in_ready), 64'd0);
      if (h < hold) begin @(posedge clk); #1; end
    end
    wr_ready = 1'b1;
    @(posedge clk); #1;
    wr_ready = 1'b0;
    chk("we_done", 64'(write_enable), 64'd0);
    nwr++;
  endtask
  task automatic no_write(input string tag);
    chk(tag, 64'(write_enable), 64'd0);
    chk("rdy_idle", 64'(in_ready), 64'd1);
  endtask
  initial begin
    #1;
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_we", 64'(write_enable), 64'd0);
    chk("rst_addr", 64'(addr_out), 64'(BASE));
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_cnt", 64'(hit_counts), 64'd0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    set_rule(4'd0, 2'd1, 48'h0011_2233_4455);
    mk(48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 8'd6, 32'h0A00_0001, 32'h0A00_0002, 16'h04D2, 16'h162E);
    send(12, 6'd0, 1, -1, 0);
    take_write(16'h0001, 0);
    chk("cnt_a1", 64'(hit_counts), 64'h0001);
    send(12, 6'd0, 1, -1, 0);
    take_write(16'h0001, 0);
    chk("cnt_a2", 64'(hit_counts), 64'h0002);
    set_rule(4'd1, 2'd2, 48'h0000_C0A8_0001);
    set_rule(4'd2, 2'd3, 48'h0000_0000_0050);
    mk(48'h0200_0000_0001, 48'h0200_0000_0002, 8'd6, 32'hC0A8_0001, 32'h0A00_0002, 16'h1234, 16'h0050);
    send(12, 6'd0, 1, -1, 0);
    take_write(16'h0006, 0);
    chk("cnt_tcp", 64'(hit_counts), 64'h0112);
    mk(48'h0200_0000_0001, 48'h0200_0000_0002, 8'd1, 32'hC0A8_0001, 32'h0A00_0002, 16'h1234, 16'h0050);
    send(12, 6'd0, 1, -1, 0);
    take_write(16'h0002, 0);
    chk("cnt_icmp", 64'(hit_counts), 64'h0122);
    mk(48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 8'd6, 32'h0A00_0001, 32'h0A00_0002, 16'h04D2, 16'h162E);
    send(12, 6'd1, 1, -1, 0);
    no_write("we_err");
    chk("cnt_err", 64'(hit_counts), 64'h0122);
    mk(48'h0200_0000_0001, 48'h0011_2233_4455, 8'd6, 32'h0A00_0001, 32'h0A00_0002, 16'h04D2, 16'h162E);
    send(12, 6'd0, 1, -1, 0);
    take_write(16'h0001, 5);
    chk("cnt_src", 64'(hit_counts), 64'h0123);
    mk(48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 8'd6, 32'h0A00_0001, 32'h0A00_0002, 16'h04D2, 16'h162E);
    cfg_idx = 4'd0; cfg_type = 2'd1; cfg_value = 48'h0011_2233_4466;
    send(12, 6'd0, 1, 2, 0);
    take_write(16'h0001, 0);
    chk("cnt_old", 64'(hit_counts), 64'h0124);
    send(12, 6'd0, 1, -1, 0);
    no_write("we_new_miss");
    mk(48'h0011_2233_4466, 48'hAABB_CCDD_EEFF, 8'd6, 32'h0A00_0001, 32'h0A00_0002, 16'h04D2, 16'h162E);
    send(12, 6'd0, 1, -1, 0);
    take_write(16'h0001, 0);
    chk("cnt_new", 64'(hit_counts), 64'h0125);
    clr_counts = 1'b1; @(posedge clk); #1; clr_counts = 1'b0;
    chk("cnt_clr", 64'(hit_counts), 64'h0000);
    send(12, 6'd0, 1, -1, 1);
    take_write(16'h0001, 0);
    chk("cnt_clr_win", 64'(hit_counts), 64'h0000);
    set_rule(4'd4, 2'd1, 48'h0200_0000_0001);
    mk(48'h0200_0000_0001, 48'h0200_0000_0002, 8'd6, 32'hC0A8_0001, 32'h0A00_0002, 16'h1234, 16'h0050);
    send(8, 6'd0, 1, -1, 0);
    take_write(16'h0002, 0);
    chk("cnt_short_ip", 64'(hit_counts), 64'h0010);
    mk(48'h0011_2233_4466, 48'hAABB_CCDD_EEFF, 8'd6, 32'h0A00_0001, 32'h0A00_0002, 16'h04D2, 16'h162E);
    send(2, 6'd0, 1, -1, 0);
    take_write(16'h0001, 0);
    chk("cnt_short_mac", 64'(hit_counts), 64'h0011);
    send(1, 6'd0, 1, -1, 0);
    no_write("we_single");
    mk(48'h0200_0000_0001, 48'h0200_0000_0002, 8'd6, 32'hC0A8_0001, 32'h0A00_0002, 16'h1234, 16'h0050);
    for (int i = 12; i > 3; i--) fr[i] = fr[i - 1];
    fr[3] = {16'h8100, 16'h0064};
    send(13, 6'd0, 1, -1, 0);
`ifdef SNIFFER_VLAN_EN
    take_write(16'h0006, 0);
    chk("cnt_vlan", 64'(hit_counts), 64'h0121);
`else
    no_write("we_vlan");
    chk("cnt_vlan", 64'(hit_counts), 64'h0011);
`endif
    clr_counts = 1'b1; @(posedge clk); #1; clr_counts = 1'b0;
    mk(48'h0011_2233_4466, 48'hAABB_CCDD_EEFF, 8'd6, 32'h0A00_0001, 32'h0A00_0002, 16'h04D2, 16'h162E);
    send(4, 6'd0, 0, -1, 0);
    mk(48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 8'd6, 32'h0A00_0001, 32'h0A00_0002, 16'h04D2, 16'h162E);
    send(12, 6'd0, 1, -1, 0);
    no_write("we_abort");
    chk("cnt_abort", 64'(hit_counts), 64'h0000);
    valid = 1'b1; eop = 1'b1; data_in = 32'h1234_5678;
    @(posedge clk); #1;
    valid = 1'b0; eop = 1'b0;
    no_write("we_stray");
    mk(48'h0011_2233_4466, 48'hAABB_CCDD_EEFF, 8'd6, 32'h0A00_0001, 32'h0A00_0002, 16'h04D2, 16'h162E);
    while (nwr < 257) begin
      send(12, 6'd0, 1, -1, 0);
      take_write(16'h0001, 0);
    end
    chk("wrap_addr", 64'(addr_out), 64'(BASE + 32'd4));
    chk("cnt_sat", 64'(hit_counts), 64'h000F);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
